// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue stage.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } seq_state_t;

  // All-ones quotient substituted on divide-by-zero; sliced to the operand width by users.
  localparam logic [63:0] DEN_ZERO_COC = '1;

endpackage

// File: rtl/divisor_fifo.sv
// Synchronous FIFO of operand pairs with async clear; PROF must be a power of two.
module divisor_fifo #(
  parameter int unsigned W    = 64,
  parameter int unsigned PROF = 4
) (
  input  logic                  CLK,
  input  logic                  RSTa,
  input  logic                  push,
  input  logic [W-1:0]          wdata,
  input  logic                  pop,
  output logic [W-1:0]          rdata,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(PROF):0] count
);

  localparam int unsigned AW = $clog2(PROF);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [PROF];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(PROF));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy next state; pointers wrap naturally modulo PROF.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/divisor_secuenciador.sv
// Issue stage for the sequential signed divider: queues operand pairs, runs one division at a time,
// substitutes divide-by-zero results and aborts a divider that never reports done.
module divisor_secuenciador
  import div_pkg::*;
#(
  parameter int unsigned tamanyo = 32,
  parameter int unsigned PROF    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [tamanyo-1:0] in_num,
  input  logic [tamanyo-1:0] in_den,
  output logic               div_start,
  output logic [tamanyo-1:0] div_num,
  output logic [tamanyo-1:0] div_den,
  input  logic [tamanyo-1:0] div_coc,
  input  logic [tamanyo-1:0] div_res,
  input  logic               div_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [tamanyo-1:0] out_coc,
  output logic [tamanyo-1:0] out_res,
  output logic               out_dbz,
  output logic               out_tmo,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam int unsigned FW   = $clog2(PROF) + 1;

  seq_state_t           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [tamanyo-1:0]   num_q, num_d, den_q, den_d;
  logic [tamanyo-1:0]   coc_q, coc_d, res_q, res_d;
  logic                 dbz_q, dbz_d, tmo_q, tmo_d;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]        fifo_count;
  logic [2*tamanyo-1:0] fifo_head;
  logic [tamanyo-1:0]   head_num, head_den;

  divisor_fifo #(
    .W    (2 * tamanyo),
    .PROF (PROF)
  ) u_fifo (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .push  (in_valid),
    .wdata ({in_num, in_den}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_num, head_den} = fifo_head;

  assign in_ready  = !fifo_full;
  assign div_start = (state_q == ISSUE);
  assign out_valid = (state_q == HOLD);
  assign div_num   = num_q;
  assign div_den   = den_q;
  assign out_coc   = coc_q;
  assign out_res   = res_q;
  assign out_dbz   = dbz_q;
  assign out_tmo   = tmo_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

  // Sequencer next state: pop, issue, wait for done or timeout, hold the result for the consumer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    den_d    = den_q;
    coc_d    = coc_q;
    res_d    = res_q;
    dbz_d    = dbz_q;
    tmo_d    = tmo_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          num_d    = head_num;
          den_d    = head_den;
          if (head_den == '0) begin
            coc_d   = DEN_ZERO_COC[tamanyo-1:0];
            res_d   = head_num;
            dbz_d   = 1'b1;
            tmo_d   = 1'b0;
            state_d = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          coc_d   = div_coc;
          res_d   = div_res;
          dbz_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Abort lands exactly TIMEOUT cycles after the start pulse.
          if (cnt_d == CntW'(TIMEOUT - 1)) begin
            coc_d   = '0;
            res_d   = '0;
            dbz_d   = 1'b0;
            tmo_d   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          dbz_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, operand and result registers; reset drops any in-flight work.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      coc_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_divisor_secuenciador.sv
// Scoreboard bench: expected results are queued at accept time, a monitor compares on each handshake.
module tb_divisor_secuenciador;

  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [31:0] coc;
    logic [31:0] res;
    logic        dbz;
    logic        tmo;
  } res_t;

  logic        CLK = 1'b0;
  logic        RSTa;
  logic        in_valid, in_ready;
  logic [31:0] in_num, in_den;
  logic        div_start;
  logic [31:0] div_num, div_den, div_coc, div_res;
  logic        div_done;
  logic        out_valid, out_ready;
  logic [31:0] out_coc, out_res;
  logic        out_dbz, out_tmo, busy;

  divisor_secuenciador #(
    .tamanyo (32),
    .PROF    (4),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .RSTa      (RSTa),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_den    (in_den),
    .div_start (div_start),
    .div_num   (div_num),
    .div_den   (div_den),
    .div_coc   (div_coc),
    .div_res   (div_res),
    .div_done  (div_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coc   (out_coc),
    .out_res   (out_res),
    .out_dbz   (out_dbz),
    .out_tmo   (out_tmo),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  res_t sb[$];
  int   rdy_mode = 0;    // 0: never ready, 1: always, 2: random
  int   lat_fixed = 35;  // divider latency, 0 selects random
  bit   div_hang = 1'b0; // divider never answers

  // Monitor state
  bit          start_since = 1'b0;
  bit          prev_start = 1'b0;
  bit          prev_valid = 1'b0;
  bit          hold_pend = 1'b0;
  res_t        held;
  int          start_cyc = 0;
  logic [31:0] snum, sden;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Consumer ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Behavioural divider: latched operands, level done after a latency, dropped on the next start.
  initial begin
    bit          st, arm;
    int          cnt;
    logic [31:0] n, d, dn, dd;
    arm = 1'b0;
    cnt = 0;
    div_done = 1'b0;
    div_coc = '0;
    div_res = '0;
    forever begin
      @(negedge CLK);
      st = div_start;
      n = div_num;
      d = div_den;
      @(posedge CLK);
      #1;
      if (st) begin
        div_done = 1'b0;
        arm = !div_hang;
        cnt = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 40);
        dn = n;
        dd = d;
      end else if (arm) begin
        if (cnt <= 1) begin
          div_done = 1'b1;
          div_coc = $signed(dn) / $signed(dd);
          div_res = $signed(dn) % $signed(dd);
          arm = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Output monitor
  initial begin
    res_t cur, e;
    forever begin
      @(negedge CLK);
      if (RSTa) begin
        cur = res_t'({out_coc, out_res, out_dbz, out_tmo});
        if (div_start) begin
          chk(!start_since && !prev_start, "start_single_no_overlap", {start_since, prev_start}, 0);
          start_since = 1'b1;
          start_cyc = cyc;
          snum = div_num;
          sden = div_den;
        end else if (start_since && !out_valid) begin
          chk(div_num == snum && div_den == sden, "operands_stable", {div_num, div_den},
              {snum, sden});
        end
        prev_start = div_start;
        if (hold_pend) chk(out_valid && cur == held, "hold_stable", {out_valid, cur}, {1'b1, held});
        hold_pend = 1'b0;
        if (out_valid && !prev_valid && out_tmo)
          chk(cyc - start_cyc == TIMEOUT, "tmo_latency", cyc - start_cyc, TIMEOUT);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_result", cur, 0);
          end else begin
            e = sb.pop_front();
            chk(cur == e, "result", cur, e);
            chk(start_since == !e.dbz, "start_count", start_since, !e.dbz);
          end
          start_since = 1'b0;
        end else if (out_valid) begin
          hold_pend = 1'b1;
          held = cur;
        end
        prev_valid = out_valid;
      end
    end
  end

  task automatic push(input logic [31:0] n, input logic [31:0] d);
    int   waited;
    res_t e;
    waited = 0;
    @(posedge CLK);
    #1;
    in_valid = 1'b1;
    in_num = n;
    in_den = d;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      waited++;
      if (waited > 500) begin
        chk(1'b0, "push_timeout", waited, 500);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge CLK);
    if (d == 0) e = '{coc: '1, res: n, dbz: 1'b1, tmo: 1'b0};
    else if (div_hang) e = '{coc: '0, res: '0, dbz: 1'b0, tmo: 1'b1};
    else e = '{coc: $signed(n) / $signed(d), res: $signed(n) % $signed(d), dbz: 1'b0, tmo: 1'b0};
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int waited;
    waited = 0;
    while ((sb.size() != 0 || busy) && waited < 2000) begin
      @(negedge CLK);
      waited++;
    end
    chk(sb.size() == 0 && !busy, name, {sb.size(), busy}, 0);
  endtask

  task automatic check_reset_outs(input string name);
    chk({out_valid, div_start, out_dbz, out_tmo, busy, out_coc, out_res} == 0, name,
        {out_valid, div_start, out_dbz, out_tmo, busy, out_coc, out_res}, 0);
    chk(div_num == 0 && div_den == 0 && in_ready == 1'b1, {name, "_ops"},
        {div_num, div_den, in_ready}, 1);
  endtask

  function automatic logic [31:0] rnd_nz();
    logic [31:0] v;
    v = $urandom();
    if (v == 0) v = 1;
    return v;
  endfunction

  initial begin
    logic [31:0] n, d;
    in_valid = 1'b0;
    in_num = '0;
    in_den = '0;
    RSTa = 1'b0;
    #2;
    check_reset_outs("reset_state");
    repeat (2) @(negedge CLK);
    RSTa = 1'b1;

    // Single division, result held until the consumer is ready
    rdy_mode = 0;
    lat_fixed = 35;
    push(32'd100, 32'd7);
    repeat (50) @(negedge CLK);
    rdy_mode = 1;
    wait_drain("drain_single");

    // Signed pairs back to back
    rdy_mode = 0;
    push(-32'sd100, 32'd7);
    push(32'd100, -32'sd7);
    repeat (45) @(negedge CLK);
    rdy_mode = 1;
    wait_drain("drain_signed");

    // Divide by zero bypasses the divider
    push(32'd5, 32'd0);
    wait_drain("drain_dbz");

    // Fill the FIFO with the consumer stalled
    rdy_mode = 0;
    lat_fixed = 10;
    for (int i = 0; i < 5; i++) push($urandom(), rnd_nz());
    @(negedge CLK);
    chk(in_ready == 1'b0 && busy == 1'b1, "full_stall", {in_ready, busy}, 2'b01);
    rdy_mode = 1;
    push(32'd77, 32'd0);
    wait_drain("drain_full");

    // Divider hangs: abort, then the next pair still issues
    div_hang = 1'b1;
    push(32'd1234, 32'd10);
    wait_drain("drain_tmo");
    div_hang = 1'b0;
    lat_fixed = 20;
    push(32'd1234, 32'd10);
    wait_drain("drain_after_tmo");

    // Reset while waiting on the divider with pairs queued
    rdy_mode = 0;
    lat_fixed = 35;
    for (int i = 0; i < 4; i++) push($urandom(), rnd_nz());
    repeat (5) @(posedge CLK);
    #1;
    RSTa = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    sb.delete();
    start_since = 1'b0;
    prev_start = 1'b0;
    prev_valid = 1'b0;
    hold_pend = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTa = 1'b1;
    rdy_mode = 1;
    repeat (60) @(negedge CLK);
    chk(!out_valid && !busy && !div_start && in_ready, "after_reset_quiet",
        {out_valid, busy, div_start, in_ready}, 1);

    // Randomized traffic
    rdy_mode = 2;
    lat_fixed = 0;
    for (int i = 0; i < 40; i++) begin
      n = $urandom();
      d = ($urandom_range(0, 5) == 0) ? 32'd0 : rnd_nz();
      if (d == 32'hFFFF_FFFF && n == 32'h8000_0000) n = 0;
      push(n, d);
    end
    wait_drain("drain_random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
